// File: rtl/seq_pkg.sv
// Shared encodings for the sequence-detector link.
// Used by seq_pattern_gen and seq_detector_2.
package seq_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_REP_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shifting register, serial MSB out.
// Load has priority over shift.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q, sr_d;

  // next contents: load, shift left, or hold
  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = din;
    else if (shift) sr_d = {sr_q[W-2:0], 1'b0};
  end

  // storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter, MSB first, reps+1 times.
// SEQ_GEN_GAP_EN: one idle GAP cycle between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(PAT_W);
  localparam logic [CW-1:0] LAST = CW'(PAT_W - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sr_load, sr_shift, sr_msb;
  logic             emit_first;

  // remaining bits of the current repetition
  seq_shift_reg #(.W(PAT_W)) u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   ({pat_q[PAT_W-2:0], 1'b0}),
    .msb   (sr_msb)
  );

  // next state, counters and registered outputs
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    cnt_d      = cnt_q;
    x_d        = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    emit_first = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          emit_first = 1'b1;
          state_d    = S_SHIFT;
        end else if (start) begin
          pend_d = 1'b1;
          pat_d  = pattern;
          rep_d  = reps;
        end
      end
      S_SHIFT: begin
        if (cnt_q != LAST) begin
          sr_shift = 1'b1;
          x_d      = sr_msb;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
`ifdef SEQ_GEN_GAP_EN
          state_d = S_GAP;
          busy_d  = 1'b1;
`else
          emit_first = 1'b1;
`endif
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        emit_first = 1'b1;
        state_d    = S_SHIFT;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (emit_first) begin
      sr_load = 1'b1;
      x_d     = pat_q[PAT_W-1];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      cnt_d   = '0;
    end
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      pat_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: vector table, corner
// sequences and random traffic against a frame-queue model.
module tb_seq_pattern_gen;

  localparam int PW = 4;
  localparam int RW = 4;
`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [RW-1:0] reps = '0;
  logic          x, valid, busy, done;

  int checks = 0;
  int failures = 0;

  // expected {x,valid,busy,done} per cycle after each edge
  logic [3:0] mq[$];
  logic [3:0] exp_o = '0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PW), .REP_W(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  // a frame is: one latency cycle, (reps+1) patterns with
  // optional gaps between them, a done cycle, a return-to-idle
  // cycle; start is only heard when no frame is in flight
  function automatic void model_edge();
    if (rst) begin
      mq.delete();
      exp_o = 4'b0000;
    end else begin
      if (mq.size() == 0 && start) begin
        mq.push_back(4'b0000);
        for (int r = 0; r <= int'(reps); r++) begin
          for (int b = PW - 1; b >= 0; b--)
            mq.push_back({pattern[b], 3'b110});
          if (GAP && r < int'(reps)) mq.push_back(4'b0010);
        end
        mq.push_back(4'b0001);
        mq.push_back(4'b0000);
      end
      exp_o = (mq.size() != 0) ? mq.pop_front() : 4'b0000;
    end
  endfunction

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s,
                      input logic [PW-1:0] p,
                      input logic [RW-1:0] n,
                      input string name);
    rst = r;
    start = s;
    pattern = p;
    reps = n;
    @(posedge clk);
    model_edge();
    #1;
    chk(name, int'({x, valid, busy, done}), int'(exp_o));
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [3:0] p;
    logic [3:0] n;
    logic [3:0] e;
  } vec_t;

  vec_t tv[10];

  int bcnt, dcnt, gcnt, nbits;
  logic [63:0] bits;
  logic prev_done;

  initial begin
    tv[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'b0000};
    tv[1] = '{1'b0, 1'b1, 4'hB, 4'h0, 4'b0000};
    tv[2] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b1110};
    tv[3] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b0110};
    tv[4] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b1110};
    tv[5] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b1110};
    tv[6] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b0001};
    tv[7] = '{1'b0, 1'b0, 4'h0, 4'h5, 4'b0000};
    tv[8] = '{1'b1, 1'b1, 4'hF, 4'h3, 4'b0000};
    tv[9] = '{1'b0, 1'b0, 4'hF, 4'h3, 4'b0000};

    // basic frame and reset/start collision, from the table
    for (int i = 0; i < 10; i++) begin
      step(tv[i].r, tv[i].s, tv[i].p, tv[i].n, "tbl_model");
      chk("tbl", int'({x, valid, busy, done}), int'(tv[i].e));
    end

    // 1010 x3: bitstream, busy length, gaps, single done
    step(1'b0, 1'b1, 4'b1010, 4'd2, "t2_start");
    bcnt = 0; dcnt = 0; gcnt = 0; nbits = 0; bits = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), "t2");
      if (valid) begin
        bits = {bits[62:0], x};
        nbits++;
      end
      if (busy) bcnt++;
      if (busy && !valid) gcnt++;
      if (done) dcnt++;
    end
    chk("t2_nbits", nbits, 12);
    chk("t2_bits", int'(bits[11:0]), 12'b1010_1010_1010);
    chk("t2_busy", bcnt, GAP ? 14 : 12);
    chk("t2_gaps", gcnt, GAP ? 2 : 0);
    chk("t2_done", dcnt, 1);

    // start at bit 2 and during the done cycle is ignored
    step(1'b0, 1'b1, 4'b1100, 4'd0, "t4_start");
    bcnt = 0; dcnt = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i == 2) || prev_done, 4'b0111, 4'd3, "t4");
      if (busy) bcnt++;
      if (done) dcnt++;
      prev_done = done;
    end
    chk("t4_busy", bcnt, 4);
    chk("t4_done", dcnt, 1);

    // reset mid-frame aborts, restart works
    step(1'b0, 1'b1, 4'b0110, 4'd3, "t5_start");
    step(1'b0, 1'b0, 4'b0110, 4'd3, "t5_b0");
    step(1'b0, 1'b0, 4'b0110, 4'd3, "t5_b1");
    step(1'b0, 1'b0, 4'b0110, 4'd3, "t5_b2");
    step(1'b1, 1'b0, 4'b0110, 4'd3, "t5_rst");
    chk("t5_zero", int'({x, valid, busy, done}), 0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'b0000, 4'd0, "t5_idle");
      if (done) dcnt++;
    end
    chk("t5_nodone", dcnt, 0);
    step(1'b0, 1'b1, 4'b1001, 4'd0, "t5_restart");
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 4'b0000, 4'd0, "t5_frame");

    // maximum repetitions: counter must not wrap
    step(1'b0, 1'b1, 4'b1001, 4'd15, "tmax_start");
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 90; i++) begin
      step(1'b0, 1'b0, 4'b0000, 4'd0, "tmax");
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    chk("tmax_busy", bcnt, GAP ? 79 : 64);
    chk("tmax_done", dcnt, 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 5) == 0),
           4'($urandom),
           ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                       : 4'($urandom_range(0, 2)),
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
